// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory stage: FSM state encoding, funct3
// access-size/sign constants, byte-enable base patterns and a helper that
// forces a lane offset to the natural alignment of an access size.
// ---------------------------------------------------------------------------
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_RESP = 2'd2
    } state_t;

    // Full funct3 codes for loads/stores (bit 2 = zero-extend on loads)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Access size, taken from funct3[1:0]
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Byte-enable patterns for lane 0; shifted by the lane offset
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Clear the offset bits that are below the access size.
    function automatic logic [1:0] align_offset(input logic [1:0] size,
                                                input logic [1:0] offset);
        case (size)
            SIZE_BYTE: align_offset = offset;
            SIZE_HALF: align_offset = {offset[1], 1'b0};
            default:   align_offset = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Combinational load-data extraction: selects the byte/halfword lane given
// by the (already aligned) offset and sign- or zero-extends it.
// Ports:
//   rdata  [31:0] in   raw word returned by data memory
//   offset [1:0]  in   byte offset of the access within the word
//   funct3 [2:0]  in   access size (bits 1:0) and unsigned flag (bit 2)
//   data   [31:0] out  extracted, extended load value
// ---------------------------------------------------------------------------
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_bit;

    always_comb begin
        byte_sel = 8'h00;
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        sign_bit = 1'b0;
        data     = rdata;
        case (funct3[1:0])
            SIZE_BYTE: begin
                sign_bit = ~funct3[2] & byte_sel[7];
                data     = {{24{sign_bit}}, byte_sel};
            end
            SIZE_HALF: begin
                sign_bit = ~funct3[2] & half_sel[15];
                data     = {{16{sign_bit}}, half_sel};
            end
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_top.sv
// ---------------------------------------------------------------------------
// mem_stage_top
// Pipeline MEM stage: holds the instruction from EX in the M register,
// drives a single-outstanding-load data memory request interface, stalls
// upstream while a memory op is in flight and produces registered
// writeback results.
// Optional feature macro: MEM_MISALIGN_TRAP_EN -- when defined, misaligned
// halfword/word accesses issue no request, complete with wb_reg_write=0
// and pulse misalign_exc; when undefined, addresses are force-aligned.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   ex_valid, alu_result, rs2_out,
//   rd_out, funct3, reg_write_out,
//   mem_read_out, mem_write_out,
//   mem_to_reg_out                  EX stage inputs
//   stall                           hold EX and earlier stages
//   dmem_req/we/addr/wdata/be       data memory request
//   dmem_ready, dmem_rvalid,
//   dmem_rdata                      data memory handshake / response
//   wb_valid, wb_reg_write, wb_rd,
//   wb_data                         writeback outputs
//   misalign_exc                    misaligned access flag (macro only)
// ---------------------------------------------------------------------------
module mem_stage_top
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_out,
    input  logic [4:0]  rd_out,
    input  logic [2:0]  funct3,
    input  logic        reg_write_out,
    input  logic        mem_read_out,
    input  logic        mem_write_out,
    input  logic        mem_to_reg_out,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign_exc
`endif
);

    // M register
    logic        m_valid_reg;
    logic [31:0] m_addr_reg;
    logic [31:0] m_wdata_reg;
    logic [4:0]  m_rd_reg;
    logic [2:0]  m_funct3_reg;
    logic        m_reg_write_reg;
    logic        m_mem_read_reg;
    logic        m_mem_write_reg;
    logic        m_mem_to_reg_reg;

    // WB registers
    logic        wb_valid_reg;
    logic        wb_reg_write_reg;
    logic [4:0]  wb_rd_reg;
    logic [31:0] wb_data_reg;
    logic        misalign_exc_reg;

    state_t      state_reg, state_next;

    logic        m_is_load, m_is_store, m_is_mem;
    logic [1:0]  m_size;
    logic [1:0]  lane_offset;
    logic        misaligned;
    logic        access_ok;
    logic        accept;
    logic        load_done;
    logic        complete;
    logic [31:0] load_data;
    logic [31:0] wb_data_next;

    // Load takes priority when both read and write are flagged.
    assign m_is_load  = m_valid_reg & m_mem_read_reg;
    assign m_is_store = m_valid_reg & m_mem_write_reg & ~m_mem_read_reg;
    assign m_is_mem   = m_is_load | m_is_store;
    assign m_size     = m_funct3_reg[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned  = m_is_mem &
                         (((m_size == SIZE_HALF) & m_addr_reg[0]) |
                          ((m_size != SIZE_BYTE) & (m_size != SIZE_HALF) &
                           (m_addr_reg[1:0] != 2'b00)));
    assign lane_offset = m_addr_reg[1:0];
    assign misalign_exc = misalign_exc_reg;
`else
    assign misaligned  = 1'b0;
    assign lane_offset = align_offset(m_size, m_addr_reg[1:0]);
`endif

    assign access_ok = m_is_mem & ~misaligned;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_REQ: begin
                if (!access_ok) begin
                    state_next = ST_IDLE;
                end else if (dmem_ready) begin
                    state_next = m_is_load ? ST_WAIT_RESP : ST_IDLE;
                end else begin
                    state_next = ST_REQ;
                end
            end
            ST_WAIT_RESP: begin
                if (dmem_rvalid) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / completion ----------------
    always_comb begin
        dmem_req  = access_ok & (state_reg != ST_WAIT_RESP);
        accept    = dmem_req & dmem_ready;
        // Responses are only meaningful while a load is outstanding.
        load_done = (state_reg == ST_WAIT_RESP) & dmem_rvalid;
        complete  = m_valid_reg & (~m_is_mem | misaligned |
                                   (m_is_store & accept) |
                                   (m_is_load & load_done));
        stall     = m_is_mem & ~complete;
    end

    // Request fields come straight from M, which is frozen while stalled,
    // so they stay stable until the request is accepted.
    assign dmem_we   = dmem_req & m_is_store;
    assign dmem_addr = {m_addr_reg[31:2], 2'b00};

    always_comb begin
        dmem_be = 4'b0000;
        if (access_ok) begin
            case (m_size)
                SIZE_BYTE: dmem_be = BE_BYTE << lane_offset;
                SIZE_HALF: dmem_be = BE_HALF << lane_offset;
                default:   dmem_be = BE_WORD;
            endcase
        end
    end

    // Store data lane replication: each lane picks the byte of the source
    // that lands there for the current access size.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wdata_lane
            always_comb begin
                case (m_size)
                    SIZE_BYTE: dmem_wdata[8*gi +: 8] = m_wdata_reg[7:0];
                    SIZE_HALF: dmem_wdata[8*gi +: 8] = m_wdata_reg[8*(gi%2) +: 8];
                    default:   dmem_wdata[8*gi +: 8] = m_wdata_reg[8*gi +: 8];
                endcase
            end
        end
    endgenerate

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .offset (lane_offset),
        .funct3 (m_funct3_reg),
        .data   (load_data)
    );

    // A trapped access has no memory data; report its address instead.
    assign wb_data_next = (m_mem_to_reg_reg & ~misaligned) ? load_data : m_addr_reg;

    // ---------------- M register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_reg      <= 1'b0;
            m_addr_reg       <= 32'h0;
            m_wdata_reg      <= 32'h0;
            m_rd_reg         <= 5'd0;
            m_funct3_reg     <= 3'd0;
            m_reg_write_reg  <= 1'b0;
            m_mem_read_reg   <= 1'b0;
            m_mem_write_reg  <= 1'b0;
            m_mem_to_reg_reg <= 1'b0;
        end else if (!stall) begin
            m_valid_reg      <= ex_valid;
            m_addr_reg       <= alu_result;
            m_wdata_reg      <= rs2_out;
            m_rd_reg         <= rd_out;
            m_funct3_reg     <= funct3;
            m_reg_write_reg  <= reg_write_out;
            m_mem_read_reg   <= mem_read_out;
            m_mem_write_reg  <= mem_write_out;
            m_mem_to_reg_reg <= mem_to_reg_out;
        end
    end

    // ---------------- WB registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_reg     <= 1'b0;
            wb_reg_write_reg <= 1'b0;
            wb_rd_reg        <= 5'd0;
            wb_data_reg      <= 32'h0;
            misalign_exc_reg <= 1'b0;
        end else if (complete) begin
            wb_valid_reg     <= 1'b1;
            wb_reg_write_reg <= m_reg_write_reg & ~misaligned;
            wb_rd_reg        <= m_rd_reg;
            wb_data_reg      <= wb_data_next;
            misalign_exc_reg <= misaligned;
        end else begin
            wb_valid_reg     <= 1'b0;
            wb_reg_write_reg <= 1'b0;
            misalign_exc_reg <= 1'b0;
        end
    end

    assign wb_valid     = wb_valid_reg;
    assign wb_reg_write = wb_reg_write_reg;
    assign wb_rd        = wb_rd_reg;
    assign wb_data      = wb_data_reg;

`ifndef MEM_MISALIGN_TRAP_EN
    // misalign_exc_reg only reaches a port when the trap is enabled.
    logic unused_misalign;
    assign unused_misalign = misalign_exc_reg;
`endif

endmodule

// File: tb/tb_mem_stage_top.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_top
// Directed self-checking bench for mem_stage_top. Expected writeback
// results are pushed to a scoreboard queue when an instruction is driven
// and popped when the stage reports wb_valid.
// ---------------------------------------------------------------------------
module tb_mem_stage_top;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] alu_result, rs2_out;
    logic [4:0]  rd_out;
    logic [2:0]  funct3;
    logic        reg_write_out, mem_read_out, mem_write_out, mem_to_reg_out;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_exc;
`endif

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        rw;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    wb_exp_t exp_item;
    wb_exp_t got;
    int      pass_cnt = 0;
    int      chk_cnt  = 0;

    always #5 clk = ~clk;

    mem_stage_top dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .alu_result     (alu_result),
        .rs2_out        (rs2_out),
        .rd_out         (rd_out),
        .funct3         (funct3),
        .reg_write_out  (reg_write_out),
        .mem_read_out   (mem_read_out),
        .mem_write_out  (mem_write_out),
        .mem_to_reg_out (mem_to_reg_out),
        .stall          (stall),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_be        (dmem_be),
        .dmem_ready     (dmem_ready),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .wb_valid       (wb_valid),
        .wb_reg_write   (wb_reg_write),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign_exc   (misalign_exc)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] alu, input logic [31:0] rs2,
                            input logic [4:0] rd, input logic [2:0] f3, input logic rw,
                            input logic mr, input logic mw, input logic m2r);
        ex_valid       = v;
        alu_result     = alu;
        rs2_out        = rs2;
        rd_out         = rd;
        funct3         = f3;
        reg_write_out  = rw;
        mem_read_out   = mr;
        mem_write_out  = mw;
        mem_to_reg_out = m2r;
    endtask

    task automatic drive_idle();
        drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        dmem_ready = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        #1;
        chk_cnt++;
        if ({stall, dmem_req, dmem_we, wb_valid, wb_reg_write} !== 5'b0)
            $display("FAIL reset_ctrl: got stall/req/we/wbv/wbrw=%b want 00000", {stall, dmem_req, dmem_we, wb_valid, wb_reg_write});
        else pass_cnt++;
        chk_cnt++;
        if ({wb_rd, wb_data, dmem_addr, dmem_wdata, dmem_be} !== 105'b0)
            $display("FAIL reset_data: got rd=%0d data=%h addr=%h wdata=%h be=%b want all 0", wb_rd, wb_data, dmem_addr, dmem_wdata, dmem_be);
        else pass_cnt++;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        $display("reset: done");
    endtask

    task automatic test_alu();
        dmem_ready = 1'b1;
        drive_ex(1'b1, 32'h0000_1234, 32'h0, 5'd5, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back('{rd: 5'd5, data: 32'h0000_1234, rw: 1'b1});
        tick();
        drive_idle();
        chk_cnt++;
        if (stall !== 1'b0 || wb_valid !== 1'b0)
            $display("FAIL alu_m_cycle: got stall=%b wb_valid=%b want 0 0", stall, wb_valid);
        else pass_cnt++;
        tick();
        got = {wb_rd, wb_data, wb_reg_write};
        chk_cnt++;
        if (wb_valid !== 1'b1 || exp_q.size() == 0)
            $display("FAIL alu_wb_valid: got wb_valid=%b queued=%0d want 1", wb_valid, exp_q.size());
        else begin
            exp_item = exp_q.pop_front();
            if (got !== exp_item) $display("FAIL alu_wb: got rd=%0d data=%h rw=%b want rd=%0d data=%h rw=%b", got.rd, got.data, got.rw, exp_item.rd, exp_item.data, exp_item.rw);
            else pass_cnt++;
        end
        tick();
        chk_cnt++;
        if (wb_valid !== 1'b0) $display("FAIL alu_wb_once: got wb_valid=%b want 0", wb_valid);
        else pass_cnt++;
        $display("alu: ADD rd=5 data=%h", got.data);
    endtask

    task automatic test_store_byte();
        dmem_ready = 1'b1;
        drive_ex(1'b1, 32'h0000_0103, 32'h0000_00AB, 5'd0, F3_LB, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_q.push_back('{rd: 5'd0, data: 32'h0000_0103, rw: 1'b0});
        tick();
        drive_idle();
        chk_cnt++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall} !== {1'b1, 1'b1, 32'h100, 4'b1000, 32'hABAB_ABAB, 1'b0})
            $display("FAIL sb_req: got req=%b we=%b addr=%h be=%b wdata=%h stall=%b want 1 1 100 1000 ababaBAB 0", dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall);
        else pass_cnt++;
        tick();
        got = {wb_rd, wb_data, wb_reg_write};
        chk_cnt++;
        if (wb_valid !== 1'b1 || exp_q.size() == 0)
            $display("FAIL sb_wb_valid: got wb_valid=%b queued=%0d want 1", wb_valid, exp_q.size());
        else begin
            exp_item = exp_q.pop_front();
            if (got !== exp_item) $display("FAIL sb_wb: got rd=%0d data=%h rw=%b want rd=%0d data=%h rw=%b", got.rd, got.data, got.rw, exp_item.rd, exp_item.data, exp_item.rw);
            else pass_cnt++;
        end
        $display("store_byte: be=1000 wdata=ABABABAB addr=100");
    endtask

    task automatic test_load(input logic [2:0] f3, input logic [31:0] rdata,
                             input logic [31:0] want, input logic [31:0] addr,
                             input logic [3:0] want_be, input string name);
        dmem_ready = 1'b1;
        dmem_rdata = 32'h5A5A_5A5A;
        drive_ex(1'b1, addr, 32'h0, 5'd7, f3, 1'b1, 1'b1, 1'b0, 1'b1);
        exp_q.push_back('{rd: 5'd7, data: want, rw: 1'b1});
        tick();
        drive_idle();
        chk_cnt++;
        if ({stall, dmem_req, dmem_we, dmem_addr, dmem_be} !== {1'b1, 1'b1, 1'b0, {addr[31:2], 2'b00}, want_be})
            $display("FAIL %s_req: got stall=%b req=%b we=%b addr=%h be=%b want 1 1 0 %h %b", name, stall, dmem_req, dmem_we, dmem_addr, dmem_be, {addr[31:2], 2'b00}, want_be);
        else pass_cnt++;
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        #1;
        chk_cnt++;
        if ({stall, dmem_req, wb_valid} !== 3'b000)
            $display("FAIL %s_resp: got stall=%b req=%b wb_valid=%b want 0 0 0", name, stall, dmem_req, wb_valid);
        else pass_cnt++;
        tick();
        dmem_rvalid = 1'b0;
        got = {wb_rd, wb_data, wb_reg_write};
        chk_cnt++;
        if (wb_valid !== 1'b1 || exp_q.size() == 0)
            $display("FAIL %s_wb_valid: got wb_valid=%b queued=%0d want 1", name, wb_valid, exp_q.size());
        else begin
            exp_item = exp_q.pop_front();
            if (got !== exp_item) $display("FAIL %s_wb: got rd=%0d data=%h rw=%b want rd=%0d data=%h rw=%b", name, got.rd, got.data, got.rw, exp_item.rd, exp_item.data, exp_item.rw);
            else pass_cnt++;
        end
        $display("%s: addr=%h rdata=%h wb_data=%h", name, addr, rdata, got.data);
    endtask

    task automatic test_lw_wait();
        dmem_ready = 1'b0;
        drive_ex(1'b1, 32'h0000_0200, 32'h0, 5'd9, F3_LW, 1'b1, 1'b1, 1'b0, 1'b1);
        exp_q.push_back('{rd: 5'd9, data: 32'hDEAD_BEEF, rw: 1'b1});
        tick();
        // Next instruction waits on the EX inputs for the whole stall.
        drive_ex(1'b1, 32'h0000_0055, 32'h0, 5'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back('{rd: 5'd3, data: 32'h0000_0055, rw: 1'b1});
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ready = 1'b1;
            #1;
            chk_cnt++;
            if ({dmem_req, dmem_we, dmem_addr, dmem_be, stall} !== {1'b1, 1'b0, 32'h200, 4'b1111, 1'b1})
                $display("FAIL lw_wait_hold%0d: got req=%b we=%b addr=%h be=%b stall=%b want 1 0 200 1111 1", i, dmem_req, dmem_we, dmem_addr, dmem_be, stall);
            else pass_cnt++;
            tick();
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEAD_BEEF;
        #1;
        chk_cnt++;
        if ({stall, dmem_req} !== 2'b00)
            $display("FAIL lw_wait_resp: got stall=%b req=%b want 0 0", stall, dmem_req);
        else pass_cnt++;
        tick();
        dmem_rvalid = 1'b0;
        drive_idle();
        for (int k = 0; k < 2; k++) begin
            got = {wb_rd, wb_data, wb_reg_write};
            chk_cnt++;
            if (wb_valid !== 1'b1 || exp_q.size() == 0)
                $display("FAIL lw_wait_wb_valid%0d: got wb_valid=%b queued=%0d want 1", k, wb_valid, exp_q.size());
            else begin
                exp_item = exp_q.pop_front();
                if (got !== exp_item) $display("FAIL lw_wait_wb%0d: got rd=%0d data=%h rw=%b want rd=%0d data=%h rw=%b", k, got.rd, got.data, got.rw, exp_item.rd, exp_item.data, exp_item.rw);
                else pass_cnt++;
            end
            tick();
        end
        chk_cnt++;
        if (wb_valid !== 1'b0) $display("FAIL lw_wait_no_dup: got wb_valid=%b want 0", wb_valid);
        else pass_cnt++;
        $display("lw_wait: held 4 cycles, LW then ADD written back");
    endtask

    task automatic test_back_to_back();
        dmem_ready = 1'b1;
        drive_ex(1'b1, 32'h0000_0011, 32'h0, 5'd1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back('{rd: 5'd1, data: 32'h0000_0011, rw: 1'b1});
        tick();
        drive_ex(1'b1, 32'h0000_0206, 32'h1234_BEEF, 5'd0, F3_LH, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_q.push_back('{rd: 5'd0, data: 32'h0000_0206, rw: 1'b0});
        tick();
        chk_cnt++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall} !== {1'b1, 1'b1, 32'h204, 4'b1100, 32'hBEEF_BEEF, 1'b0})
            $display("FAIL b2b_sh_req: got req=%b we=%b addr=%h be=%b wdata=%h stall=%b want 1 1 204 1100 beefbeef 0", dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall);
        else pass_cnt++;
        drive_ex(1'b1, 32'h0000_0033, 32'h0, 5'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back('{rd: 5'd3, data: 32'h0000_0033, rw: 1'b1});
        for (int k = 0; k < 3; k++) begin
            got = {wb_rd, wb_data, wb_reg_write};
            chk_cnt++;
            if (wb_valid !== 1'b1 || exp_q.size() == 0)
                $display("FAIL b2b_wb_valid%0d: got wb_valid=%b queued=%0d want 1", k, wb_valid, exp_q.size());
            else begin
                exp_item = exp_q.pop_front();
                if (got !== exp_item) $display("FAIL b2b_wb%0d: got rd=%0d data=%h rw=%b want rd=%0d data=%h rw=%b", k, got.rd, got.data, got.rw, exp_item.rd, exp_item.data, exp_item.rw);
                else pass_cnt++;
            end
            tick();
            if (k == 0) drive_idle();
        end
        $display("back_to_back: ADD, SH, ADD");
    endtask

`ifdef MEM_MISALIGN_TRAP_EN
    task automatic test_misalign();
        dmem_ready = 1'b1;
        drive_ex(1'b1, 32'h0000_0101, 32'h0, 5'd4, F3_LW, 1'b1, 1'b1, 1'b0, 1'b1);
        exp_q.push_back('{rd: 5'd4, data: 32'h0000_0101, rw: 1'b0});
        tick();
        drive_idle();
        chk_cnt++;
        if ({dmem_req, stall} !== 2'b00)
            $display("FAIL misalign_noreq: got req=%b stall=%b want 0 0", dmem_req, stall);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (misalign_exc !== 1'b1) $display("FAIL misalign_exc_hi: got %b want 1", misalign_exc);
        else pass_cnt++;
        got = {wb_rd, wb_data, wb_reg_write};
        chk_cnt++;
        if (wb_valid !== 1'b1 || exp_q.size() == 0)
            $display("FAIL misalign_wb_valid: got wb_valid=%b queued=%0d want 1", wb_valid, exp_q.size());
        else begin
            exp_item = exp_q.pop_front();
            if (got !== exp_item) $display("FAIL misalign_wb: got rd=%0d data=%h rw=%b want rd=%0d data=%h rw=%b", got.rd, got.data, got.rw, exp_item.rd, exp_item.data, exp_item.rw);
            else pass_cnt++;
        end
        tick();
        chk_cnt++;
        if ({misalign_exc, wb_valid} !== 2'b00)
            $display("FAIL misalign_exc_lo: got exc=%b wb_valid=%b want 0 0", misalign_exc, wb_valid);
        else pass_cnt++;
        $display("misalign: LW addr 101 trapped");
    endtask
`endif

    task automatic test_reset_wait();
        dmem_ready = 1'b1;
        drive_ex(1'b1, 32'h0000_0300, 32'h0, 5'd6, F3_LW, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        drive_idle();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({stall, dmem_req, wb_valid} !== 3'b000 || dut.state_reg !== ST_IDLE)
            $display("FAIL rstwait_assert: got stall=%b req=%b wb_valid=%b state=%0d want 0 0 0 IDLE", stall, dmem_req, wb_valid, dut.state_reg);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFE_F00D;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk_cnt++;
            if (wb_valid !== 1'b0 || dut.state_reg !== ST_IDLE || stall !== 1'b0)
                $display("FAIL rstwait_ignore%0d: got wb_valid=%b state=%0d stall=%b want 0 IDLE 0", k, wb_valid, dut.state_reg, stall);
            else pass_cnt++;
        end
        dmem_rvalid = 1'b0;
        $display("reset_wait: abandoned load, late rvalid ignored");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_store_byte();
        test_load(F3_LB,  32'h0080_0000, 32'hFFFF_FF80, 32'h0000_0102, 4'b0100, "lb");
        test_load(F3_LBU, 32'h0080_0000, 32'h0000_0080, 32'h0000_0102, 4'b0100, "lbu");
`ifndef MEM_MISALIGN_TRAP_EN
        // Odd halfword address is force-aligned to the upper halfword.
        test_load(F3_LH,  32'h8001_1234, 32'hFFFF_8001, 32'h0000_0103, 4'b1100, "lh_force_align");
`endif
        test_lw_wait();
        test_back_to_back();
`ifdef MEM_MISALIGN_TRAP_EN
        test_misalign();
`endif
        test_reset_wait();
        chk_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_empty: got %0d entries left want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
